// File: rtl/noc_pe_interface.sv
// rtl/noc_pe_interface.sv - PE-side network interface: TX holding register, always-ready RX FIFO, self-addressed loopback.
module noc_pe_interface #(
  parameter int x_coord     = 0,
  parameter int y_coord     = 0,
  parameter int data_width  = 256,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int RX_DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [data_width-1:0]  s_data,
  input  logic [x_size-1:0]      s_dest_x,
  input  logic [y_size-1:0]      s_dest_y,
  output logic                   o_valid_noc,
  output logic [total_width-1:0] o_data_noc,
  input  logic                   i_ready_noc,
  input  logic                   i_valid_noc,
  input  logic [total_width-1:0] i_data_noc,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [data_width-1:0]  m_data,
  output logic                   err_overflow,
  input  logic                   clr_err,
  output logic [15:0]            drop_count
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = x_size + y_size;
  localparam logic [x_size-1:0] X_LOC = x_size'(x_coord);
  localparam logic [y_size-1:0] Y_LOC = y_size'(y_coord);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic                   tx_valid_q, tx_valid_d;
  logic [total_width-1:0] tx_data_q, tx_data_d;
  logic [AW:0]            wr_q, wr_d, rd_q, rd_d;
  logic                   err_q, err_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [data_width-1:0]  mem [RX_DEPTH];

  logic                  is_local;
  logic                  fifo_empty, fifo_full, fifo_full_eff;
  logic                  pop, drop, net_wr, lb_wr, tx_load, wr_en;
  logic [data_width-1:0] wr_data;
  logic                  unused_rx_coords;

  assign is_local = (s_dest_x == X_LOC) && (s_dest_y == Y_LOC);

  assign fifo_empty    = (wr_q == rd_q);
  assign fifo_full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop           = m_ready && !fifo_empty;
  assign fifo_full_eff = fifo_full && !pop;

  // The ejection port cannot be stalled, so a network flit wins the write port over a loopback.
  assign s_ready = is_local ? (!fifo_full_eff && !i_valid_noc)
                            : (!tx_valid_q || i_ready_noc);

  assign net_wr  = i_valid_noc && !fifo_full_eff;
  assign drop    = i_valid_noc && fifo_full_eff;
  assign lb_wr   = s_valid && is_local && s_ready;
  assign tx_load = s_valid && !is_local && s_ready;
  assign wr_en   = net_wr || lb_wr;
  assign wr_data = i_valid_noc ? i_data_noc[total_width-1:CW] : s_data;

  assign unused_rx_coords = ^i_data_noc[CW-1:0];

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_valid_q && i_ready_noc) begin
      tx_valid_d = 1'b0;
    end
    if (tx_load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = {s_data, s_dest_y, s_dest_x};
    end
  end

  always_comb begin
    wr_d = wr_en ? (wr_q + PTR_ONE) : wr_q;
    rd_d = pop   ? (rd_q + PTR_ONE) : rd_q;
  end

  // A clear in the same cycle as a drop still counts that drop, but leaves the flag low.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (clr_err) begin
      err_d = 1'b0;
      cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      err_d = 1'b1;
      cnt_d = (cnt_q != 16'hFFFF) ? (cnt_q + 16'd1) : cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_q[AW-1:0]] <= wr_data;
    end
  end

  assign o_valid_noc  = tx_valid_q;
  assign o_data_noc   = tx_data_q;
  assign m_valid      = !fifo_empty;
  assign m_data       = mem[rd_q[AW-1:0]];
  assign err_overflow = err_q;
  assign drop_count   = cnt_q;

endmodule
